unidade_controle: RTL



---
 rtl/unidade_controle_pkg.sv | 24 ++
 rtl/unidade_controle.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_pkg.sv
// State encodings for the memory-game control unit; db_estado carries these codes.
package unidade_controle_pkg;

    typedef enum logic [4:0] {
        Inicial         = 5'h00,
        Preparacao      = 5'h01,
        IniciaRodada    = 5'h02,
        ExibeDado       = 5'h03,
        ProximoDado     = 5'h04,
        IniciaJogadas   = 5'h05,
        EsperaJogada    = 5'h06,
        Registra        = 5'h07,
        Compara         = 5'h08,
        ProximaJogada   = 5'h09,
        ProximoEscrita  = 5'h0A,
        EsperaEscrita   = 5'h0B,
        RegistraEscrita = 5'h0C,
        Escreve         = 5'h0D,
        FimAcertou      = 5'h0E,
        FimErrou        = 5'h0F,
        FimTimeout      = 5'h10
    } estado_t;

endpackage

// File: rtl/unidade_controle.sv
// Moore FSM sequencing the memory-game datapath: replay, player check, new-move write.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimRodada,
    input  logic       fimTotal,
    input  logic       igual,
    input  logic       jogada_feita,
    input  logic       fimTimeout,
    input  logic       fimExibicao,
    output logic       zeraCL,
    output logic       contaCL,
    output logic       registraModo,
    output logic       zeraC,
    output logic       contaC,
    output logic       escreve,
    output logic       zeraR,
    output logic       registraR,
    output logic       contaTimeout,
    output logic       zeraTimeout,
    output logic       contaExibicao,
    output logic       zeraExibicao,
    output logic       resetEdgeDetector,
    output logic       seletorLedsBM,
    output logic       mostraLeds,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [4:0] db_estado
);

    estado_t estadoAtual, proximoEstado;

    always_ff @(posedge clock) begin
        if (!reset) estadoAtual <= Inicial;
        else        estadoAtual <= proximoEstado;
    end

    always_comb begin
        proximoEstado = estadoAtual;
        case (estadoAtual)
            Inicial:         if (iniciar) proximoEstado = Preparacao;
            Preparacao:      proximoEstado = IniciaRodada;
            IniciaRodada:    proximoEstado = ExibeDado;
            ExibeDado: begin
                if (fimExibicao) proximoEstado = fimRodada ? IniciaJogadas : ProximoDado;
            end
            ProximoDado:     proximoEstado = ExibeDado;
            IniciaJogadas:   proximoEstado = EsperaJogada;
            // A move arriving with the timeout still counts.
            EsperaJogada: begin
                if (jogada_feita)    proximoEstado = Registra;
                else if (fimTimeout) proximoEstado = FimTimeout;
            end
            Registra:        proximoEstado = Compara;
            Compara: begin
                if (!igual)         proximoEstado = FimErrou;
                else if (!fimRodada) proximoEstado = ProximaJogada;
                else if (fimTotal)  proximoEstado = FimAcertou;
                else                proximoEstado = ProximoEscrita;
            end
            ProximaJogada:   proximoEstado = EsperaJogada;
            ProximoEscrita:  proximoEstado = EsperaEscrita;
            EsperaEscrita: begin
                if (jogada_feita)    proximoEstado = RegistraEscrita;
                else if (fimTimeout) proximoEstado = FimTimeout;
            end
            RegistraEscrita: proximoEstado = Escreve;
            Escreve:         proximoEstado = IniciaRodada;
            FimAcertou, FimErrou, FimTimeout: begin
                if (iniciar) proximoEstado = Preparacao;
            end
            default:         proximoEstado = Inicial;
        endcase
    end

    always_comb begin
        zeraCL            = 1'b0;
        contaCL           = 1'b0;
        registraModo      = 1'b0;
        zeraC             = 1'b0;
        contaC            = 1'b0;
        escreve           = 1'b0;
        zeraR             = 1'b0;
        registraR         = 1'b0;
        contaTimeout      = 1'b0;
        zeraTimeout       = 1'b0;
        contaExibicao     = 1'b0;
        zeraExibicao      = 1'b0;
        resetEdgeDetector = 1'b0;
        seletorLedsBM     = 1'b0;
        mostraLeds        = 1'b0;
        pronto            = 1'b0;
        ganhou            = 1'b0;
        perdeu            = 1'b0;
        db_timeout        = 1'b0;
        case (estadoAtual)
            Preparacao: begin
                zeraCL            = 1'b1;
                zeraC             = 1'b1;
                zeraR             = 1'b1;
                zeraTimeout       = 1'b1;
                zeraExibicao      = 1'b1;
                registraModo      = 1'b1;
                resetEdgeDetector = 1'b1;
            end
            IniciaRodada: begin
                zeraC        = 1'b1;
                zeraR        = 1'b1;
                zeraExibicao = 1'b1;
            end
            ExibeDado: begin
                contaExibicao = 1'b1;
                mostraLeds    = 1'b1;
                seletorLedsBM = 1'b1;
            end
            ProximoDado: begin
                contaC       = 1'b1;
                zeraExibicao = 1'b1;
            end
            IniciaJogadas: begin
                zeraC             = 1'b1;
                zeraR             = 1'b1;
                zeraTimeout       = 1'b1;
                resetEdgeDetector = 1'b1;
            end
            EsperaJogada, EsperaEscrita: contaTimeout = 1'b1;
            Registra, RegistraEscrita: begin
                registraR  = 1'b1;
                mostraLeds = 1'b1;
            end
            Compara:     mostraLeds = 1'b1;
            ProximaJogada, ProximoEscrita: begin
                contaC      = 1'b1;
                zeraTimeout = 1'b1;
            end
            // Address held still so the write lands on the current position.
            Escreve: begin
                escreve = 1'b1;
                contaCL = 1'b1;
            end
            FimAcertou: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FimErrou: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FimTimeout: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estadoAtual;

endmodule
